// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Handles stall (hold), jump/branch redirect (bubble insertion) and a one-cycle boot state after reset.
module if_id_fetch_stage #(
    parameter int                 ADDR_W    = 64,
    parameter int                 INSTR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               jump,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic               if_id_valid,
    output logic [6:0]         opcode,
    output logic [31:0]        fetch_count
);

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] if_id_instr_q, if_id_instr_d;
    logic [ADDR_W-1:0]  if_id_pc_q, if_id_pc_d;
    logic               if_id_valid_q, if_id_valid_d;
    logic [31:0]        fetch_count_q, fetch_count_d;

    logic               redirect;
    logic [ADDR_W-1:0]  target_raw;
    logic [ADDR_W-1:0]  target_aligned;

    // Jump has priority over branch when both resolve in the same cycle.
    assign redirect       = jump | branch_taken;
    assign target_raw     = jump ? jump_target : branch_target;
    assign target_aligned = {target_raw[ADDR_W-1:2], 2'b00};

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_valid_d = if_id_valid_q;
        fetch_count_d = fetch_count_q;

        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (redirect) begin
                    pc_d = target_aligned;
                end
            end
            RUN: begin
                if (redirect) begin
                    pc_d          = target_aligned;
                    if_id_instr_d = NOP_INSTR;
                    if_id_pc_d    = '0;
                    if_id_valid_d = 1'b0;
                end else if (!stall) begin
                    if_id_instr_d = imem_rdata;
                    if_id_pc_d    = pc_q;
                    if_id_valid_d = 1'b1;
                    pc_d          = pc_q + ADDR_W'(4);
                    fetch_count_d = fetch_count_q + 32'd1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            if_id_instr_q <= NOP_INSTR;
            if_id_pc_q    <= '0;
            if_id_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_valid_q <= if_id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_valid = if_id_valid_q;
    assign opcode      = if_id_instr_q[6:0];
    assign fetch_count = fetch_count_q;

endmodule
